// File: rtl/dbg_mem2axil_bridge.sv
// dbg_mem2axil_bridge: debug-module MEM master port to single-outstanding AXI4-Lite master.
// Define DBG_MEM2AXIL_ERRCNT_EN to add err_count_o, a saturating count of SLVERR/DECERR responses.
module dbg_mem2axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_i,
  output logic                  mem_gnt_o,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [STRB_WIDTH-1:0] mem_be_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_error_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,
  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,
  input  logic [1:0]            m_axi_bresp_i,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [2:0]            m_axi_arprot_o,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i
`ifdef DBG_MEM2AXIL_ERRCNT_EN
  ,
  output logic [15:0]           err_count_o
`endif
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic error_q, error_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, b_err, r_err;
  // bus addresses are word aligned: the low byte-lane bits are dropped
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign mem_gnt_o       = rst_ni & mem_req_i & (state_q == IDLE);
  assign mem_valid_o     = state_q == RESP;
  assign mem_rdata_o     = rdata_q;
  assign mem_error_o     = error_q;
  assign m_axi_awvalid_o = (state_q == WR_REQ) & ~aw_done_q;
  assign m_axi_wvalid_o  = (state_q == WR_REQ) & ~w_done_q;
  assign m_axi_awaddr_o  = addr_q & ALIGN_MASK;
  assign m_axi_araddr_o  = addr_q & ALIGN_MASK;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = be_q;
  assign m_axi_bready_o  = state_q == WR_RESP;
  assign m_axi_arvalid_o = state_q == RD_REQ;
  assign m_axi_rready_o  = state_q == RD_RESP;
  assign aw_hs = m_axi_awvalid_o & m_axi_awready_i;
  assign w_hs  = m_axi_wvalid_o & m_axi_wready_i;
  assign b_hs  = m_axi_bvalid_i & m_axi_bready_o;
  assign ar_hs = m_axi_arvalid_o & m_axi_arready_i;
  assign r_hs  = m_axi_rvalid_i & m_axi_rready_o;
  // SLVERR and DECERR both carry resp[1]; OKAY and EXOKAY do not
  assign b_err = (m_axi_bresp_i & 2'b10) != 2'b00;
  assign r_err = (m_axi_rresp_i & 2'b10) != 2'b00;
  // state and captured request/response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  // next state, request capture on grant, response capture on B/R handshake
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: if (mem_req_i) begin
        addr_d    = mem_addr_i;
        be_d      = mem_be_i;
        wdata_d   = mem_wdata_i;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = mem_we_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        state_d   = (aw_done_d & w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (b_hs) begin
        rdata_d = '0;
        error_d = b_err;
        state_d = RESP;
      end
      RD_REQ: state_d = ar_hs ? RD_RESP : RD_REQ;
      RD_RESP: if (r_hs) begin
        rdata_d = m_axi_rdata_i;
        error_d = r_err;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef DBG_MEM2AXIL_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  assign err_cnt_d   = (((b_hs & b_err) | (r_hs & r_err)) && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  assign err_count_o = err_cnt_q;
  // saturating count of error responses on either channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
`endif
endmodule

// File: tb/tb_dbg_mem2axil_bridge.sv
// tb_dbg_mem2axil_bridge: scoreboard bench with a timed AXI4-Lite slave model
module tb_dbg_mem2axil_bridge;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic mem_req = 1'b0, mem_gnt, mem_we = 1'b0, mem_valid, mem_error;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0] mem_be = '0;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0] wstrb;
  logic [2:0] awprot, arprot;
  logic [1:0] bresp, rresp;
`ifdef DBG_MEM2AXIL_ERRCNT_EN
  logic [15:0] err_count;
  int ec_exp = 0;
`endif
  dbg_mem2axil_bridge dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_be_i(mem_be), .mem_wdata_i(mem_wdata), .mem_valid_o(mem_valid), .mem_rdata_o(mem_rdata),
    .mem_error_o(mem_error),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awaddr_o(awaddr), .m_axi_awprot_o(awprot),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready), .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb),
    .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready), .m_axi_bresp_i(bresp),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_araddr_o(araddr), .m_axi_arprot_o(arprot),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp)
`ifdef DBG_MEM2AXIL_ERRCNT_EN
    , .err_count_o(err_count)
`endif
  );
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] be; logic [1:0] resp; int a_dly; int w_dly; int d_dly;} tr_t;
  typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
  tr_t pend[$], sq[$], t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, gcyc = 0, n_gnt = 0;
  int rel = 0, r_at = 0, b_at = 0;
  logic active = 1'b0, ar_done, aw_done, w_done, r_done, b_done;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic tr_t mk(logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be, logic [1:0] rs, int ad, int wd, int dd);
    tr_t r;
    r.we = we; r.addr = a; r.data = d; r.be = be; r.resp = rs; r.a_dly = ad; r.w_dly = wd; r.d_dly = dd;
    return r;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // scoreboard: pop the expected response whenever the bridge reports one
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mem_gnt && mem_req) begin n_gnt++; gcyc = cyc; end
    if (mem_valid) begin
      chk("gnt_in_valid", mem_gnt, 0);
      if (exp_q.size() == 0) chk("unexpected_valid", mem_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", mem_rdata, e.data);
        chk("error", mem_error, e.err);
        chk("latency", cyc - gcyc, e.lat);
`ifdef DBG_MEM2AXIL_ERRCNT_EN
        if (e.err) ec_exp++;
        chk("err_count", err_count, ec_exp);
`endif
      end
    end
  end
  // AXI slave: readiness and response timing counted from the grant cycle
  initial begin
    {arready, awready, wready, rvalid, bvalid} = '0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        sq.delete();
      end else if (mem_gnt && mem_req) begin
        if (sq.size() > 0) t = sq[0];
        active = 1'b1; rel = 0; r_at = 0; b_at = 0;
        {ar_done, aw_done, w_done, r_done, b_done} = '0;
      end else if (active) begin
        chk("gnt_busy", mem_gnt, 0);
        if (!t.we) begin
          chk("arvalid", arvalid, !ar_done);
          chk("rready", rready, ar_done && !r_done);
          if (!ar_done) chk("araddr", araddr, t.addr & ~32'h3);
          if (arvalid && arready) begin ar_done = 1'b1; r_at = rel + 1 + t.d_dly; chk("arprot", arprot, 0); end
          if (rvalid && rready) begin r_done = 1'b1; void'(sq.pop_front()); end
        end else begin
          chk("awvalid", awvalid, !aw_done);
          chk("wvalid", wvalid, !w_done);
          chk("bready", bready, aw_done && w_done && !b_done);
          if (!aw_done) chk("awaddr", awaddr, t.addr & ~32'h3);
          if (!w_done) chk("wdata_strb", {wstrb, wdata}, {t.be, t.data});
          if (awvalid && awready) begin aw_done = 1'b1; chk("awprot", awprot, 0); end
          if (wvalid && wready) w_done = 1'b1;
          if (aw_done && w_done && b_at == 0) b_at = rel + 1 + t.d_dly;
          if (bvalid && bready) begin b_done = 1'b1; void'(sq.pop_front()); end
        end
        if (mem_valid) active = 1'b0;
      end
      @(posedge clk); #1;
      rel++;
      arready = active && !t.we && !ar_done && rel >= 1 + t.a_dly;
      awready = active && t.we && !aw_done && rel >= 1 + t.a_dly;
      wready  = active && t.we && !w_done && rel >= 1 + t.w_dly;
      rvalid  = active && ar_done && !r_done && rel >= r_at;
      bvalid  = active && aw_done && w_done && !b_done && rel >= b_at;
      rdata   = rvalid ? t.data : 32'h0;
      rresp   = rvalid ? t.resp : 2'b00;
      bresp   = bvalid ? t.resp : 2'b00;
    end
  end
  // issue every pending request, holding mem_req high until each grant
  task automatic drive_all();
    tr_t p;
    exp_t e;
    logic got;
    @(posedge clk); #1;
    while (pend.size() > 0) begin
      p = pend.pop_front();
      sq.push_back(p);
      e.data = p.we ? 32'h0 : p.data;
      e.err = p.resp[1];
      e.lat = 3 + (p.we ? (p.a_dly > p.w_dly ? p.a_dly : p.w_dly) : p.a_dly) + p.d_dly;
      exp_q.push_back(e);
      mem_req = 1'b1; mem_we = p.we; mem_addr = p.addr; mem_wdata = p.data; mem_be = p.be;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); got = mem_gnt; end
      chk("gnt_timeout", got, 1);
      @(posedge clk); #1;
    end
    mem_req = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 600 && exp_q.size() > 0; i++) @(negedge clk);
    chk("done_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g0;
    mem_req = 1'b1;
    #12;
    chk("rst_gnt", mem_gnt, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_data", {mem_rdata, mem_error}, 0);
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pend.push_back(mk(1'b0, 32'h1000_0006, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0));
    drive_all(); wait_done();
    pend.push_back(mk(1'b1, 32'h2000_0008, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 1));
    drive_all(); wait_done();
    pend.push_back(mk(1'b0, 32'h1000_0010, 32'h0BAD_0BAD, 4'hF, 2'b11, 0, 0, 0));
    drive_all(); wait_done();
    pend.push_back(mk(1'b1, 32'h2000_0013, 32'hA5A5_5A5A, 4'b1100, 2'b10, 0, 2, 0));
    drive_all(); wait_done();
    pend.push_back(mk(1'b0, 32'h3000_0004, 32'h7777_0001, 4'hF, 2'b01, 1, 0, 2));
    drive_all(); wait_done();
    g0 = n_gnt;
    for (int i = 0; i < 3; i++) pend.push_back(mk(1'b0, 32'h4000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 2'b00, 0, 0, 0));
    drive_all(); wait_done();
    chk("b2b_grants", n_gnt - g0, 3);
    pend.push_back(mk(1'b0, 32'h5000_0020, 32'hFEED_FACE, 4'hF, 2'b00, 20, 0, 0));
    drive_all(); wait_done();
    for (int i = 0; i < 8; i++)
      pend.push_back(mk(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)), 2'($urandom_range(3)),
                        $urandom_range(3), $urandom_range(3), $urandom_range(3)));
    drive_all(); wait_done();
    pend.push_back(mk(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 0, 10));
    drive_all();
    for (int i = 0; i < 50 && !bready; i++) @(negedge clk);
    chk("bready_seen", bready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, mem_valid, mem_gnt}, 0);
    chk("mid_rst_data", {mem_rdata, mem_error, awaddr}, 0);
`ifdef DBG_MEM2AXIL_ERRCNT_EN
    chk("mid_rst_errcnt", err_count, 0);
    ec_exp = 0;
`endif
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pend.push_back(mk(1'b0, 32'h6000_000C, 32'h1357_9BDF, 4'hF, 2'b00, 0, 0, 0));
    drive_all(); wait_done();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
